// File: rtl/lsq_slot_tracker_if.sv
// Handshake bundle between the LSQ slot tracker, the dispatch/completion
// pipeline and the slot free-list queue.
interface lsq_slot_tracker_if #(
   parameter int SLOTIDW = 4
);
   // dispatch side
   logic               DispValid;
   logic               DispReady;
   logic [SLOTIDW-1:0] AllocId;
   // completion / flush side
   logic               CmplValid;
   logic [SLOTIDW-1:0] CmplId;
   logic               Flush;
   // free-list side
   logic [SLOTIDW-1:0] FreePreOut;
   logic               FreeEmpty;
   logic               FreeFull;
   logic               FreeRable;
   logic               FreeWable;
   logic [SLOTIDW-1:0] FreeDin;
   logic               FreeClean;
   // retire / statistics
   logic               RetireValid;
   logic [SLOTIDW-1:0] RetireId;
   logic [15:0]        StallCnt;

   // environment side: drives requests and free-list status
   modport master (
      output DispValid, CmplValid, CmplId, Flush, FreePreOut, FreeEmpty, FreeFull,
      input  DispReady, AllocId, FreeRable, FreeWable, FreeDin, FreeClean,
             RetireValid, RetireId, StallCnt
   );

   // tracker side
   modport slave (
      input  DispValid, CmplValid, CmplId, Flush, FreePreOut, FreeEmpty, FreeFull,
      output DispReady, AllocId, FreeRable, FreeWable, FreeDin, FreeClean,
             RetireValid, RetireId, StallCnt
   );
endinterface

// File: rtl/lsq_slot_tracker.sv
// In-order age tracker for LSQ slots. Pops free slot IDs on dispatch, keeps
// them in program order, marks them done on completion and pushes the head
// back to the free list once it is done. Flush empties the queue and asks
// the free list to reinitialise.
// Optional feature: define LSQ_SLOT_STALL_STATS_EN to build the saturating
// counter of dispatches blocked by an empty free list (StallCnt); otherwise
// StallCnt is tied to zero.
module lsq_slot_tracker #(
   parameter int SLOTIDW = 4,
   parameter int AGEDEEP = 4
) (
   input  logic              Clk,
   input  logic              Rest,
   lsq_slot_tracker_if.slave bus
);
   localparam int AW = $clog2(AGEDEEP);
   localparam int PW = AW + 1;

   // age queue storage: ids are plain data, done bits are control
   logic [SLOTIDW-1:0] id_q [AGEDEEP];
   logic [AGEDEEP-1:0] done_q, done_d;
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;

   logic [AW-1:0]      head_idx, tail_idx;
   logic [PW-1:0]      count;
   logic [AGEDEEP-1:0] occ;
   logic               q_full, q_empty;
   logic               disp_ready, alloc, retire;

   assign head_idx = head_q[AW-1:0];
   assign tail_idx = tail_q[AW-1:0];
   assign count    = tail_q - head_q;
   assign q_full   = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
   assign q_empty  = (head_q == tail_q);

   // grant and retire decisions; retire looks only at the registered done bit
   assign disp_ready = !bus.FreeEmpty && !q_full && !bus.Flush;
   assign alloc      = bus.DispValid && disp_ready;
   assign retire     = !q_empty && done_q[head_idx] && !bus.FreeFull && !bus.Flush;

   assign bus.DispReady   = disp_ready;
   assign bus.AllocId     = bus.FreePreOut;
   assign bus.FreeRable   = alloc;
   assign bus.FreeWable   = retire;
   assign bus.FreeDin     = retire ? id_q[head_idx] : '0;
   assign bus.RetireValid = retire;
   assign bus.RetireId    = retire ? id_q[head_idx] : '0;
   assign bus.FreeClean   = bus.Flush;

   // an entry is live when its distance from the head is below the occupancy
   always_comb begin
      occ = '0;
      for (int i = 0; i < AGEDEEP; i++) begin
         logic [AW-1:0] off;
         off    = AW'(i) - head_idx;
         occ[i] = ({1'b0, off} < count);
      end
   end

   // next done bits: flush clears, allocate clears the new tail, completion sets matches
   always_comb begin
      done_d = done_q;
      if (bus.Flush) begin
         done_d = '0;
      end else begin
         if (alloc) begin
            done_d[tail_idx] = 1'b0;
         end
         if (bus.CmplValid) begin
            for (int i = 0; i < AGEDEEP; i++) begin
               if (occ[i] && (id_q[i] == bus.CmplId)) begin
                  done_d[i] = 1'b1;
               end
            end
         end
      end
   end

   // next pointers: flush rewinds both, otherwise advance on allocate / retire
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (bus.Flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (retire) begin
            head_d = head_q + 1'b1;
         end
         if (alloc) begin
            tail_d = tail_q + 1'b1;
         end
      end
   end

   // control state register
   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         head_q <= '0;
         tail_q <= '0;
         done_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         done_q <= done_d;
      end
   end

   // slot id capture at the tail on allocate
   always_ff @(posedge Clk) begin
      if (alloc) begin
         id_q[tail_idx] <= bus.FreePreOut;
      end
   end

`ifdef LSQ_SLOT_STALL_STATS_EN
   logic [15:0] stall_q, stall_d;

   // count blocked dispatches, saturating; flush cycles do not count
   always_comb begin
      stall_d = stall_q;
      if (bus.DispValid && bus.FreeEmpty && !bus.Flush && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // stall counter register, cleared only by reset
   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.StallCnt = stall_q;
`else
   assign bus.StallCnt = '0;
`endif

endmodule

// File: tb/tb_lsq_slot_tracker.sv
// Directed bench for lsq_slot_tracker: a vector table walking allocate,
// complete, retire, wrap and flush scenarios, then hand sequences for
// mid-operation reset and the stall counter.
module tb_lsq_slot_tracker;
   logic Clk;
   logic Rest;
   int   n_tests;
   int   n_fail;

   lsq_slot_tracker_if #(.SLOTIDW(4)) bus ();

   lsq_slot_tracker #(.SLOTIDW(4), .AGEDEEP(4)) dut (
      .Clk  (Clk),
      .Rest (Rest),
      .bus  (bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic       dv;
      logic       cv;
      logic [3:0] cid;
      logic       fl;
      logic [3:0] fpo;
      logic       fe;
      logic       ff;
      logic       rdy;
      logic       rable;
      logic       clean;
      logic       rv;
      logic [3:0] rid;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic dv, cv, input logic [3:0] cid, input logic fl,
                               input logic [3:0] fpo, input logic fe, ff,
                               input logic rdy, rable, clean, rv, input logic [3:0] rid);
      vec_t v;
      v.dv = dv; v.cv = cv; v.cid = cid; v.fl = fl; v.fpo = fpo; v.fe = fe; v.ff = ff;
      v.rdy = rdy; v.rable = rable; v.clean = clean; v.rv = rv; v.rid = rid;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic dv, cv, input logic [3:0] cid, input logic fl,
                        input logic [3:0] fpo, input logic fe, ff);
      bus.DispValid  = dv;
      bus.CmplValid  = cv;
      bus.CmplId     = cid;
      bus.Flush      = fl;
      bus.FreePreOut = fpo;
      bus.FreeEmpty  = fe;
      bus.FreeFull   = ff;
   endtask

   initial begin
      logic [15:0] exp_stall;
      n_tests = 0;
      n_fail  = 0;

      //  dv cv cid fl fpo fe ff | rdy rab cln rv rid
      // three grants from free list {0,4,8}, then empty free list
      add(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 4, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 8, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      // complete out of order: 4, 8, then head 0; retires follow in order
      add(0, 1, 4, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 1, 8, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4);
      add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 8);
      add(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
      // unmatched completion ignored; then retire and allocate together
      add(1, 0, 0, 0, 2, 0, 0,  1, 1, 0, 0, 0);
      add(0, 1, 9, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      add(0, 1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 6, 0, 0,  1, 1, 0, 1, 2);
      // fill to AGEDEEP, blocked when full, retire frees one, tail wraps
      add(1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 3, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 5, 0, 0,  1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 7, 0, 0,  0, 0, 0, 0, 0);
      add(1, 1, 6, 0, 7, 0, 0,  0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 7, 0, 0,  0, 0, 0, 1, 6);
      add(1, 0, 0, 0, 7, 0, 0,  1, 1, 0, 0, 0);
      // head done but free list full: no push
      add(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
      // flush with entries pending: clean only, then empty queue
      add(1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 3, 0, 0,  1, 1, 0, 0, 0);
      add(0, 1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 3);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);

      // reset state
      Rest = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_DispReady",   0, 16'(bus.DispReady), 16'h1);
      chk("rst_FreeRable",   0, 16'(bus.FreeRable), 16'h0);
      chk("rst_FreeWable",   0, 16'(bus.FreeWable), 16'h0);
      chk("rst_FreeClean",   0, 16'(bus.FreeClean), 16'h0);
      chk("rst_RetireValid", 0, 16'(bus.RetireValid), 16'h0);
      chk("rst_FreeDin",     0, 16'(bus.FreeDin), 16'h0);
      chk("rst_RetireId",    0, 16'(bus.RetireId), 16'h0);
      chk("rst_StallCnt",    0, bus.StallCnt, 16'h0);
      @(negedge Clk);
      Rest = 1'b0;

      // table-driven scenario
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge Clk);
         drive(vq[i].dv, vq[i].cv, vq[i].cid, vq[i].fl, vq[i].fpo, vq[i].fe, vq[i].ff);
         #1;
         chk("DispReady",   i, 16'(bus.DispReady),   16'(vq[i].rdy));
         chk("FreeRable",   i, 16'(bus.FreeRable),   16'(vq[i].rable));
         chk("FreeClean",   i, 16'(bus.FreeClean),   16'(vq[i].clean));
         chk("RetireValid", i, 16'(bus.RetireValid), 16'(vq[i].rv));
         chk("FreeWable",   i, 16'(bus.FreeWable),   16'(vq[i].rv));
         if (vq[i].rable) chk("AllocId", i, 16'(bus.AllocId), 16'(vq[i].fpo));
         if (vq[i].rv) begin
            chk("RetireId", i, 16'(bus.RetireId), 16'(vq[i].rid));
            chk("FreeDin",  i, 16'(bus.FreeDin),  16'(vq[i].rid));
         end
      end

      // reset asserted mid-operation with a retire pending
      @(negedge Clk);
      drive(1, 0, 0, 0, 9, 0, 0);
      @(negedge Clk);
      drive(1, 0, 0, 0, 10, 0, 0);
      @(negedge Clk);
      drive(0, 1, 9, 0, 0, 0, 0);
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("pre_rst_RetireValid", 0, 16'(bus.RetireValid), 16'h1);
      chk("pre_rst_RetireId",    0, 16'(bus.RetireId),    16'h9);
      Rest = 1'b1;
      #1;
      chk("mid_rst_RetireValid", 0, 16'(bus.RetireValid), 16'h0);
      chk("mid_rst_FreeWable",   0, 16'(bus.FreeWable),   16'h0);
      chk("mid_rst_FreeDin",     0, 16'(bus.FreeDin),     16'h0);
      chk("mid_rst_DispReady",   0, 16'(bus.DispReady),   16'h1);
      chk("mid_rst_StallCnt",    0, bus.StallCnt,         16'h0);
      @(negedge Clk);
      Rest = 1'b0;
      @(negedge Clk);
      #1;
      chk("post_rst_RetireValid", 0, 16'(bus.RetireValid), 16'h0);
      chk("post_rst_DispReady",   0, 16'(bus.DispReady),   16'h1);

      // five blocked dispatches, then one during flush which must not count
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         drive(1, 0, 0, 0, 0, 1, 0);
         #1;
         chk("stall_DispReady", k, 16'(bus.DispReady), 16'h0);
      end
      @(negedge Clk);
      drive(1, 0, 0, 1, 0, 1, 0);
      #1;
      chk("stall_flush_FreeClean", 0, 16'(bus.FreeClean), 16'h1);
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
`ifdef LSQ_SLOT_STALL_STATS_EN
      exp_stall = 16'd5;
`else
      exp_stall = 16'd0;
`endif
      chk("StallCnt", 0, bus.StallCnt, exp_stall);
      // flush does not clear the counter
      @(negedge Clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("StallCnt_after_flush", 0, bus.StallCnt, exp_stall);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lsq_slot_tracker.md
# lsq_slot_tracker

In-order age tracker for load/store queue slots, sitting directly downstream of the LSQ slot free-list queue. It pops a free slot ID from the free list on every accepted dispatch and records it in a program-ordered age queue. It marks entries done on completion and returns the head slot ID to the free list once that slot has completed. On flush it empties itself and pulses the free-list clean request.

## Interface
- `SLOTIDW`, 4, width of a slot ID (matches the free-list data width).
- `AGEDEEP`, 4, age queue entries; power of two, at least 2.
- `Clk` in 1: single clock, rising edge.
- `Rest` in 1: asynchronous reset, active-high.
- `DispValid` in 1: dispatch requests an LSQ slot.
- `DispReady` out 1: slot grant possible this cycle.
- `AllocId` out SLOTIDW: slot ID granted; valid when `DispValid && DispReady`.
- `CmplValid` in 1: an LSQ op finished.
- `CmplId` in SLOTIDW: slot ID of the finished op.
- `Flush` in 1: pipeline flush.
- `FreePreOut` in SLOTIDW: free-list head peek (combinational).
- `FreeEmpty` in 1: free list empty.
- `FreeFull` in 1: free list full.
- `FreeRable` out 1: free-list pop.
- `FreeWable` out 1: free-list push.
- `FreeDin` out SLOTIDW: ID returned to the free list.
- `FreeClean` out 1: free-list reinitialise.
- `RetireValid` out 1: head slot retired this cycle.
- `RetireId` out SLOTIDW: ID retired.
- `StallCnt` out 16: count of dispatches blocked by an empty free list.

## Operation
- State:
  - age queue of AGEDEEP entries, each holding {id, done};
  - head and tail pointers, log2(AGEDEEP)+1 bits each, with the MSB as the wrap bit.
  - Full when the low bits are equal and the MSBs differ. Empty when the pointers are equal.
- `DispReady` = !FreeEmpty && !ageFull && !Flush.
- Allocate when `DispValid && DispReady`:
  - `FreeRable`=1 and `AllocId`=`FreePreOut`, both combinational in the same cycle.
  - Entry[tail] <= {FreePreOut, 0}; tail increments and wraps.
- Complete when `CmplValid`:
  - Every occupied entry whose id == `CmplId` gets done <= 1.
  - An unmatched `CmplId` is ignored.
- Retire when the head is occupied, entry[head].done, !FreeFull and !Flush:
  - `FreeWable`=1, `FreeDin`=entry[head].id, `RetireValid`=1, `RetireId`=the same ID.
  - Head increments. At most one retire per cycle.
- Allocate and retire may occur in the same cycle; occupancy is unchanged.
- Completion of the head and retire of the head in the same cycle are not combined. The retire uses the registered done bit, so the head retires the following cycle.
- Flush:
  - `FreeClean`=1 combinationally while `Flush` is high.
  - Allocate and retire are suppressed; `FreeRable`=0, `FreeWable`=0.
  - Next edge: head <= 0, tail <= 0, all done bits cleared. `CmplValid` in that cycle is ignored.

## Timing
- Reset (`Rest` high, asynchronous):
  - head=0, tail=0, done bits 0, StallCnt=0.
  - Consequently `FreeWable`=0, `RetireValid`=0, `FreeRable`=0, `FreeClean`=0, `FreeDin`=0, `RetireId`=0.
  - `DispReady`=!FreeEmpty, since the queue is empty and `Flush` is assumed low.
- Allocation has 0-cycle latency: the grant, `AllocId` and the free-list pop all occur in the same cycle.
- Completion to retire has a minimum latency of 1 cycle: `CmplValid` at cycle N gives `RetireValid` at cycle N+1 if the entry is at the head.
- The free-list push becomes visible in `FreeEmpty` per the free-list timing. Same-cycle reuse of a just-retired ID is not possible.
- Reset asserted mid-operation discards all entries. The free list is reset by the same `Rest`.

## Configuration
- `LSQ_SLOT_STALL_STATS_EN` defined:
  - `StallCnt` increments by 1 on every cycle with `DispValid && FreeEmpty && !Flush`.
  - Saturates at 16'hFFFF. Cleared by reset only; flush does not clear it.
- `LSQ_SLOT_STALL_STATS_EN` undefined: `StallCnt` is tied to 0 and no counter logic exists.

## Test plan
- Reset and free list holding {0,4,8}. Three dispatches on consecutive cycles -> `AllocId` 0, 4, 8 with `FreeRable` each cycle. A fourth dispatch with `FreeEmpty`=1 -> `DispReady`=0.
- Allocate 0, 4, 8. Complete 4 then 8 -> no retire. Complete 0 at cycle N -> `RetireValid` with ID 0, 4, 8 at cycles N+1, N+2, N+3, each with `FreeWable`.
- Head done and `DispValid` in the same cycle -> simultaneous retire and allocate; occupancy stays constant.
- AGEDEEP=4 allocations with the free list non-empty -> the fifth dispatch gets `DispReady`=0. After one retire, the next dispatch is accepted and the tail wraps.
- `Flush` with 3 entries pending -> `FreeClean`=1 that cycle, no push or pop. Next cycle the queue is empty and `RetireValid` stays 0.
- `LSQ_SLOT_STALL_STATS_EN` defined, `DispValid` held for 5 cycles with the free list empty -> `StallCnt`=5. Macro undefined -> `StallCnt`=0.
